// File: rtl/mmcm_drp_ctrl.sv
`default_nettype none
// ============================================================================
// mmcm_drp_ctrl : DRP read-modify-write sequencer for the pixel-clock MMCM.
// Option macro DRP_TIMEOUT_EN adds DRDY/lock timeouts.  Rev 1.0
// ============================================================================
module mmcm_drp_ctrl #(
    parameter int RST_HOLD     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        SYSCLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [6:0]  CMD_ADDR,
    input  logic [15:0] CMD_MASK,
    input  logic [15:0] CMD_DATA,
    input  logic        CMD_LAST,
    output logic [6:0]  DADDR,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    output logic        DEN,
    output logic        DWE,
    input  logic        DRDY,
    output logic        MMCM_RST,
    input  logic        LOCKED,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERR_CODE,
    output logic        LOCK_LOST
);
    localparam int c_max_a = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
    localparam int c_max   = (c_max_a > LOCK_TIMEOUT) ? c_max_a : LOCK_TIMEOUT;
    localparam int c_cw    = $clog2(c_max + 1);

    localparam logic [c_cw-1:0] c_one       = c_cw'(1);
    localparam logic [c_cw-1:0] c_two       = c_cw'(2);
    localparam logic [c_cw-1:0] c_hold_last = c_cw'(RST_HOLD - 1);
`ifdef DRP_TIMEOUT_EN
    localparam logic [c_cw-1:0] c_drdy_last = c_cw'(DRDY_TIMEOUT - 1);
    localparam logic [c_cw-1:0] c_lock_last = c_cw'(LOCK_TIMEOUT - 1);
`endif

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_rst_hold  = 3'd1;
    localparam logic [2:0] c_rd_req    = 3'd2;
    localparam logic [2:0] c_rd_wait   = 3'd3;
    localparam logic [2:0] c_wr_req    = 3'd4;
    localparam logic [2:0] c_wr_wait   = 3'd5;
    localparam logic [2:0] c_wait_cmd  = 3'd6;
    localparam logic [2:0] c_wait_lock = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic [6:0]      addr_q, addr_d;
    logic [15:0]     mask_q, mask_d, data_q, data_d, wdata_q, wdata_d;
    logic            last_q, last_d;
    logic            ready_q, ready_d, den_q, den_d, dwe_q, dwe_d;
    logic            mmcm_rst_q, mmcm_rst_d, busy_q, busy_d;
    logic            done_q, done_d, err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            lock_lost_q, lock_lost_d, locked_q, locked_d;
    logic            w_accept;

    assign w_accept = ready_q & CMD_VALID;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        data_d      = data_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        mmcm_rst_d  = mmcm_rst_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        lock_lost_d = lock_lost_q;
        locked_d    = LOCKED;

        if (state_q == c_idle && locked_q && !LOCKED)
            lock_lost_d = 1'b1;

        if (w_accept) begin
            addr_d      = CMD_ADDR;
            mask_d      = CMD_MASK;
            data_d      = CMD_DATA;
            last_d      = CMD_LAST;
            mmcm_rst_d  = 1'b1;
            err_code_d  = 2'd0;
            lock_lost_d = 1'b0;
            cnt_d       = '0;
        end

        case (state_q)
            c_idle: begin
                if (w_accept) state_d = c_rst_hold;
            end
            c_rst_hold: begin
                if (cnt_q == c_hold_last) begin
                    state_d = c_rd_req;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            // The access timer starts on the DEN cycle so expiry lands DRDY_TIMEOUT after DEN.
            c_rd_req: begin
                state_d = c_rd_wait;
                cnt_d   = cnt_q + c_one;
            end
            c_rd_wait: begin
                if (DRDY) begin
                    wdata_d = (DO & ~mask_q) | (data_q & mask_q);
                    state_d = c_wr_req;
                    cnt_d   = '0;
                end
`ifdef DRP_TIMEOUT_EN
                else if (cnt_q == c_drdy_last) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    mmcm_rst_d = 1'b0;
                    state_d    = c_idle;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
`endif
            end
            c_wr_req: begin
                state_d = c_wr_wait;
                cnt_d   = cnt_q + c_one;
            end
            c_wr_wait: begin
                if (DRDY) begin
                    cnt_d = '0;
                    if (last_q) begin
                        mmcm_rst_d = 1'b0;
                        state_d    = c_wait_lock;
                    end else begin
                        state_d = c_wait_cmd;
                    end
                end
`ifdef DRP_TIMEOUT_EN
                else if (cnt_q == c_drdy_last) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    mmcm_rst_d = 1'b0;
                    state_d    = c_idle;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
`endif
            end
            c_wait_cmd: begin
                if (w_accept) state_d = c_rd_req;
            end
            c_wait_lock: begin
                // LOCKED may still reflect the pre-reset lock for a couple of cycles.
                if (cnt_q >= c_two && LOCKED) begin
                    done_d  = 1'b1;
                    state_d = c_idle;
                end
`ifdef DRP_TIMEOUT_EN
                else if (cnt_q == c_lock_last) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = c_idle;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
`else
                else if (cnt_q < c_two) begin
                    cnt_d = cnt_q + c_one;
                end
`endif
            end
            default: state_d = c_idle;
        endcase

        ready_d = (state_d == c_idle) || (state_d == c_wait_cmd);
        den_d   = (state_d == c_rd_req) || (state_d == c_wr_req);
        dwe_d   = (state_d == c_wr_req);
        busy_d  = (state_d != c_idle);
    end

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_q     <= c_idle;
            cnt_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            mmcm_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            lock_lost_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            last_q      <= last_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            mmcm_rst_q  <= mmcm_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            lock_lost_q <= lock_lost_d;
            locked_q    <= locked_d;
        end
    end

    assign CMD_READY = ready_q;
    assign DADDR     = addr_q;
    assign DI        = wdata_q;
    assign DEN       = den_q;
    assign DWE       = dwe_q;
    assign MMCM_RST  = mmcm_rst_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign ERR_CODE  = err_code_q;
    assign LOCK_LOST = lock_lost_q;
endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mmcm_drp_ctrl : self-checking bench with DRP/MMCM model and access scoreboard.
// Rev 1.0
// ============================================================================
module tb_mmcm_drp_ctrl;
    localparam int RST_HOLD_C = 8;
    localparam int DRDY_TO    = 64;
    localparam int LOCK_TO    = 300;
    localparam int LOCK_DLY   = 100;

    logic        SYSCLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [6:0]  CMD_ADDR = '0;
    logic [15:0] CMD_MASK = '0;
    logic [15:0] CMD_DATA = '0;
    logic        CMD_LAST = 1'b0;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO = '0;
    logic        DEN, DWE;
    logic        DRDY = 1'b0;
    logic        MMCM_RST;
    logic        LOCKED = 1'b0;
    logic        BUSY, DONE, ERR;
    logic [1:0]  ERR_CODE;
    logic        LOCK_LOST;

    mmcm_drp_ctrl #(
        .RST_HOLD(RST_HOLD_C), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .SYSCLK(SYSCLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_ADDR(CMD_ADDR), .CMD_MASK(CMD_MASK), .CMD_DATA(CMD_DATA), .CMD_LAST(CMD_LAST),
        .DADDR(DADDR), .DI(DI), .DO(DO), .DEN(DEN), .DWE(DWE), .DRDY(DRDY),
        .MMCM_RST(MMCM_RST), .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .ERR_CODE(ERR_CODE), .LOCK_LOST(LOCK_LOST)
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [6:0] addr;
        logic [15:0] data;
    } acc_t;
    acc_t exp_q[$];

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
        logic [15:0] do_init;
        logic [15:0] exp_di;
        int          lat;
    } vec_t;

    // DRP register file contents returned on reads; written only by the test.
    logic [15:0] mem [0:127];
    int drp_lat = 1;
    logic lock_en = 1'b1;
    int drop_seq = 0;

    // DRP + lock model, owned state
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_do = '0;
    logic        prev_den = 1'b0;
    int          den_total = 0;
    int          last_rd_den_cyc = 0;
    int          last_wr_den_cyc = 0;
    int          lcnt = 0;
    int          drop_seen = 0;
    logic        drop_restore = 1'b0;

    always @(negedge SYSCLK) begin
        acc_t e;
        if (DRDY) DRDY = 1'b0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                DRDY = 1'b1;
                DO   = pend_do;
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (DEN) begin
            den_total++;
            check("den_back_to_back", prev_den, 0);
            check("den_before_drdy", pend, 0);
            check("ready_low_in_access", CMD_READY, 0);
            check("mmcm_rst_in_access", MMCM_RST, 1);
            if (DWE) last_wr_den_cyc = cyc;
            else     last_rd_den_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("drp_unexpected_access", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("drp_we", DWE, e.we);
                check("drp_addr", DADDR, e.addr);
                if (e.we) check("drp_wdata", DI, e.data);
            end
            pend_do = mem[DADDR];
            if (drp_lat > 0) begin
                pend     = 1'b1;
                pend_cnt = drp_lat;
            end
        end
        prev_den = DEN;

        if (drop_seq != drop_seen) begin
            drop_seen    = drop_seq;
            LOCKED       = 1'b0;
            drop_restore = 1'b1;
        end else if (drop_restore) begin
            LOCKED       = 1'b1;
            drop_restore = 1'b0;
        end else if (MMCM_RST) begin
            LOCKED = 1'b0;
            lcnt   = 0;
        end else if (!LOCKED) begin
            if (lcnt < LOCK_DLY) lcnt++;
            if (lcnt >= LOCK_DLY && lock_en) LOCKED = 1'b1;
        end
    end

    // Output event monitor
    int   rst_hi_total = 0, fall_total = 0, last_fall_cyc = 0;
    int   done_total = 0, last_done_cyc = 0, err_total = 0, last_err_cyc = 0;
    logic prev_mrst = 1'b0, prev_busy = 1'b0;

    always @(negedge SYSCLK) begin
        if (MMCM_RST) rst_hi_total++;
        if (prev_mrst && !MMCM_RST) begin
            fall_total++;
            last_fall_cyc = cyc;
        end
        if (DONE) begin
            done_total++;
            last_done_cyc = cyc;
            check("busy_low_at_done", BUSY, 0);
            check("busy_before_done", prev_busy, 1);
        end
        if (ERR) begin
            err_total++;
            last_err_cyc = cyc;
        end
        prev_mrst = MMCM_RST;
        prev_busy = BUSY;
    end

    task automatic tick();
        @(negedge SYSCLK);
        #1;
    endtask

    task automatic push_exp(input logic we, input logic [6:0] a, input logic [15:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                            input logic l, output int acc);
        int n;
        n = 0;
        CMD_ADDR = a; CMD_MASK = m; CMD_DATA = d; CMD_LAST = l; CMD_VALID = 1'b1;
        while (!CMD_READY && n < 500) begin
            tick();
            n++;
        end
        if (!CMD_READY) begin
            check("cmd_ready_timeout", 0, 1);
            CMD_VALID = 1'b0;
            acc = cyc;
        end else begin
            @(posedge SYSCLK);
            tick();
            CMD_VALID = 1'b0;
            acc = cyc;
        end
    endtask

    task automatic wait_done(input int d0, input int bound);
        int n;
        n = 0;
        while (done_total == d0 && n < bound) begin
            tick();
            n++;
        end
        if (done_total == d0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_err(input int e0, input int bound);
        int n;
        n = 0;
        while (err_total == e0 && n < bound) begin
            tick();
            n++;
        end
        if (err_total == e0) check("err_timeout", 0, 1);
    endtask

    task automatic wait_locked(input int bound);
        int n;
        n = 0;
        while (!LOCKED && n < bound) begin
            tick();
            n++;
        end
        check("relock_timeout", LOCKED, 1);
    endtask

    task automatic run_single(input vec_t v);
        int acc, d0, h0, e0;
        mem[v.addr] = v.do_init;
        drp_lat = v.lat;
        push_exp(1'b0, v.addr, 16'h0);
        push_exp(1'b1, v.addr, v.exp_di);
        d0 = done_total; h0 = rst_hi_total; e0 = err_total;
        send_cmd(v.addr, v.mask, v.data, 1'b1, acc);
        check("accept_clears_lock_lost", LOCK_LOST, 0);
        check("accept_clears_err_code", ERR_CODE, 0);
        check("busy_after_accept", BUSY, 1);
        wait_done(d0, RST_HOLD_C + 4 * v.lat + LOCK_DLY + 50);
        check("hold_to_read", last_rd_den_cyc - acc, RST_HOLD_C);
        check("read_to_write", last_wr_den_cyc - last_rd_den_cyc, v.lat + 1);
        check("read_to_release", last_fall_cyc - last_rd_den_cyc, 2 * v.lat + 2);
        check("mmcm_rst_cycles", rst_hi_total - h0, RST_HOLD_C + 2 * v.lat + 2);
        check("release_to_done", last_done_cyc - last_fall_cyc, LOCK_DLY);
        check("done_pulses", done_total - d0, 1);
        check("err_pulses", err_total - e0, 0);
        check("sb_drained", exp_q.size(), 0);
        tick();
        check("ready_after_done", CMD_READY, 1);
        check("done_one_cycle", DONE, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        vec_t bt[3];
        int acc, d0, f0, e0, n0, w0;

        vt[0] = '{7'h08, 16'h003F, 16'h0015, 16'h1240, 16'h1255, 3};
        vt[1] = '{7'h09, 16'hFFFF, 16'hABCD, 16'h1234, 16'hABCD, 1};
        vt[2] = '{7'h14, 16'h0000, 16'hFFFF, 16'h5A5A, 16'h5A5A, 2};
        vt[3] = '{7'h7F, 16'hF0F0, 16'h1234, 16'hFFFF, 16'h1F3F, 5};
        vt[4] = '{7'h00, 16'h8001, 16'hFFFF, 16'h0000, 16'h8001, 1};
        bt[0] = '{7'h08, 16'h00FF, 16'h0080, 16'h1101, 16'h1180, 2};
        bt[1] = '{7'h09, 16'hFF00, 16'h3400, 16'h5678, 16'h3478, 2};
        bt[2] = '{7'h14, 16'h0F00, 16'h0A00, 16'hFFFF, 16'hFAFF, 2};
        for (int i = 0; i < 128; i++) mem[i] = 16'h0;

        // Reset values
        repeat (4) tick();
        check("rst_ctrl", {CMD_READY, DEN, DWE, MMCM_RST, BUSY, DONE, ERR, ERR_CODE, LOCK_LOST}, 0);
        check("rst_data", {DADDR, DI}, 0);
        RST = 1'b0;
        tick();
        check("ready_first_idle", CMD_READY, 1);
        check("busy_idle", BUSY, 0);
        wait_locked(300);
        check("no_lock_lost_at_start", LOCK_LOST, 0);

        // Single-command table
        for (int i = 0; i < 5; i++) run_single(vt[i]);

        // Three-command batch with 5-cycle VALID gaps
        d0 = done_total; f0 = fall_total; n0 = den_total;
        drp_lat = 2;
        for (int i = 0; i < 3; i++) begin
            mem[bt[i].addr] = bt[i].do_init;
            repeat (5) tick();
            push_exp(1'b0, bt[i].addr, 16'h0);
            push_exp(1'b1, bt[i].addr, bt[i].exp_di);
            send_cmd(bt[i].addr, bt[i].mask, bt[i].data, (i == 2), acc);
            check("batch_rst_high", MMCM_RST, 1);
            check("batch_no_release", fall_total - f0, 0);
            if (i > 0) check("batch_no_second_hold", last_rd_den_cyc, acc);
        end
        wait_done(d0, 200);
        check("batch_done_pulses", done_total - d0, 1);
        check("batch_releases", fall_total - f0, 1);
        check("batch_accesses", den_total - n0, 6);
        check("batch_sb_drained", exp_q.size(), 0);

        // Loss of lock while idle
        repeat (3) tick();
        check("lock_lost_before_drop", LOCK_LOST, 0);
        drop_seq++;
        tick();
        tick();
        check("lock_lost_set", LOCK_LOST, 1);
        repeat (10) tick();
        check("lock_lost_sticky", LOCK_LOST, 1);
        run_single(vt[0]);

        // Async reset while in WR_WAIT
        drp_lat = 20;
        mem[7'h21] = 16'h00F0;
        push_exp(1'b0, 7'h21, 16'h0);
        push_exp(1'b1, 7'h21, 16'h00FF);
        d0 = done_total; w0 = last_wr_den_cyc;
        send_cmd(7'h21, 16'h000F, 16'h000F, 1'b1, acc);
        for (int n = 0; n < 200 && last_wr_den_cyc == w0; n++) tick();
        check("reached_wr_wait", (last_wr_den_cyc != w0), 1);
        repeat (3) tick();
        RST = 1'b1;
        tick();
        check("midrst_ctrl", {CMD_READY, DEN, DWE, MMCM_RST, BUSY, DONE, ERR, ERR_CODE, LOCK_LOST}, 0);
        check("midrst_data", {DADDR, DI}, 0);
        repeat (2) tick();
        RST = 1'b0;
        repeat (30) tick();
        check("midrst_no_done", done_total - d0, 0);
        wait_locked(300);
        run_single(vt[3]);

`ifdef DRP_TIMEOUT_EN
        // DRDY never returns
        drp_lat = 0;
        push_exp(1'b0, 7'h08, 16'h0);
        e0 = err_total; d0 = done_total;
        send_cmd(7'h08, 16'h0001, 16'h0001, 1'b1, acc);
        wait_err(e0, RST_HOLD_C + DRDY_TO + 50);
        check("drdy_to_latency", last_err_cyc - last_rd_den_cyc, DRDY_TO);
        check("drdy_to_code", ERR_CODE, 1);
        check("drdy_to_mmcm_rst", MMCM_RST, 0);
        check("drdy_to_ready", CMD_READY, 1);
        check("drdy_to_sb", exp_q.size(), 0);
        check("drdy_to_no_done", done_total - d0, 0);
        wait_locked(300);
`endif

        // LOCKED held low after release
        lock_en = 1'b0;
        mem[7'h09] = 16'h0000;
        push_exp(1'b0, 7'h09, 16'h0);
        push_exp(1'b1, 7'h09, 16'h0003);
        e0 = err_total; d0 = done_total;
        send_cmd(7'h09, 16'h0003, 16'h0003, 1'b1, acc);
`ifdef DRP_TIMEOUT_EN
        wait_err(e0, RST_HOLD_C + LOCK_TO + 50);
        check("lock_to_latency", last_err_cyc - last_fall_cyc, LOCK_TO);
        check("lock_to_code", ERR_CODE, 2);
        check("lock_to_no_done", done_total - d0, 0);
        lock_en = 1'b1;
        repeat (5) tick();
        check("err_code_held", ERR_CODE, 2);
        check("idle_after_lock_to", BUSY, 0);
        wait_locked(300);
`else
        repeat (RST_HOLD_C + LOCK_TO + 50) tick();
        check("no_to_busy", BUSY, 1);
        check("no_to_err", err_total - e0, 0);
        check("no_to_code", ERR_CODE, 0);
        lock_en = 1'b1;
        wait_done(d0, 20);
        check("late_lock_done", done_total - d0, 1);
`endif
        check("lock_test_sb", exp_q.size(), 0);

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mmcm_drp_ctrl.md
# mmcm_drp_ctrl

Sequences run-time reconfiguration of the pixel-clock MMCM through its Dynamic Reconfiguration Port (DRP). Requesters stream read-modify-write commands; the controller holds the MMCM in reset, performs each DRP read and write, releases reset and waits for lock. It sits beside the PCK generator in the SYSCLK domain, with DCLK tied to SYSCLK. It also reports loss of lock while idle.

## Interface
- RST_HOLD, 8: cycles MMCM_RST is held before the first DRP access (≥1).
- DRDY_TIMEOUT, 64: max cycles waiting for DRDY per access.
- LOCK_TIMEOUT, 65535: max cycles waiting for LOCKED after reset release.
- SYSCLK  in  1  clock; also drives MMCM DCLK.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accepted when VALID&&READY.
- CMD_ADDR  in  7  DRP register address.
- CMD_MASK  in  16  1 = bit replaced by CMD_DATA; 0 = bit kept.
- CMD_DATA  in  16  new field bits.
- CMD_LAST  in  1  final command of the batch.
- DADDR  out  7  to MMCM. DI  out  16. DO  in  16. DEN  out  1. DWE  out  1. DRDY  in  1.
- MMCM_RST  out  1  MMCM reset.
- LOCKED  in  1  MMCM lock.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on successful relock.
- ERR  out  1  one-cycle pulse on timeout. ERR_CODE  out  2  1 = DRDY timeout, 2 = lock timeout; held until the next accept.
- LOCK_LOST  out  1  sticky; set when LOCKED falls while IDLE.

## Operation
- States: IDLE, RST_HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, WAIT_CMD, WAIT_LOCK.
- IDLE: CMD_READY=1. On accept, latch ADDR/MASK/DATA/LAST, set MMCM_RST=1, clear LOCK_LOST and ERR_CODE, then go to RST_HOLD.
- RST_HOLD: count RST_HOLD cycles, then go to RD_REQ.
- RD_REQ: DEN=1, DWE=0, DADDR=latched address for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: on DRDY, capture DO and compute wdata=(DO&~MASK)|(DATA&MASK), then go to WR_REQ.
- WR_REQ: DEN=1, DWE=1, DI=wdata for one cycle, then go to WR_WAIT.
- WR_WAIT: on DRDY, go to WAIT_LOCK with MMCM_RST=0 if LAST; otherwise go to WAIT_CMD.
- WAIT_CMD: CMD_READY=1 and MMCM_RST stays high. On accept, latch the command and go to RD_REQ (no second hold).
- WAIT_LOCK: ignore LOCKED for the first 2 cycles. Afterwards LOCKED=1 pulses DONE and returns to IDLE.
- CMD_READY=0 in all states except IDLE and WAIT_CMD.
- A DRDY seen outside RD_WAIT/WR_WAIT is ignored.
- LOCK_LOST is set on a LOCKED 1→0 transition while in IDLE. It is not set during reconfiguration.

## Timing
- Reset values: CMD_READY=0 during RST, 1 from the first cycle in IDLE. DEN=DWE=0, DADDR=0, DI=0, MMCM_RST=0, BUSY=0, DONE=0, ERR=0, ERR_CODE=0, LOCK_LOST=0.
- All outputs are registered.
- DEN is never high two cycles in a row. A new DEN never issues before the previous DRDY.
- Minimum per-command latency with DRDY returning 1 cycle after DEN: RD_REQ→WR_WAIT exit takes 4 cycles.
- Minimum single-command batch from accept to DONE: RST_HOLD + 4 + 2 + lock cycles.
- RST asserted mid-sequence: immediate return to IDLE, MMCM_RST=0, all pulses suppressed.
- DRDY and timeout expiry in the same cycle: DRDY wins.

## Configuration
- DRP_TIMEOUT_EN defined:
  - A timer counts in RD_WAIT/WR_WAIT. Reaching DRDY_TIMEOUT gives ERR pulse, ERR_CODE=1, MMCM_RST=0, then IDLE.
  - A timer counts in WAIT_LOCK. Reaching LOCK_TIMEOUT gives ERR pulse, ERR_CODE=2, then IDLE.
- DRP_TIMEOUT_EN undefined: no timers. The wait states wait indefinitely, ERR stays 0 and ERR_CODE stays 0.

## Test plan
- Single command: ADDR=0x08, MASK=0x003F, DATA=0x0015, LAST=1, with DO=0x1240 and DRDY 3 cycles after DEN -> write DI=0x1255 to 0x08, MMCM_RST high ≥8 cycles, LOCKED raised 100 cycles after release -> one DONE pulse, BUSY falls the same cycle.
- Three-command batch (0x08, 0x09, 0x14), VALID gaps of 5 cycles -> MMCM_RST stays high across all three, 3 reads + 3 writes in order, CMD_READY low during accesses, single DONE.
- With DRP_TIMEOUT_EN, DRDY never returns -> ERR pulse 64 cycles after DEN, ERR_CODE=1, MMCM_RST=0, CMD_READY=1 next cycle.
- With DRP_TIMEOUT_EN, LOCKED held low -> ERR at LOCK_TIMEOUT, ERR_CODE=2. Without the macro -> BUSY stays 1 and ERR stays 0.
- While IDLE, drop LOCKED for 1 cycle -> LOCK_LOST=1 and stays set. Next accepted command clears it.
- Assert RST while in WR_WAIT -> next cycle all outputs at reset values. A later command runs the full sequence including RST_HOLD.
